// File: rtl/vec_pkg.sv
// rtl/vec_pkg.sv - shared vector datapath types, default sizes and saturating-count helper
//
// Purpose : common definitions for the vector add/sub datapath and its statistics.
// Contents: LANE_W / NUM_LANES defaults, lane_t, sat_inc().
package vec_pkg;

  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 4;

  typedef logic [LANE_W-1:0] lane_t;

  // Saturating increment for counters up to 32 bits wide; max_value is the
  // all-ones value of the caller's counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value >= max_value) ? max_value : value + 32'd1;
  endfunction

endpackage

// File: rtl/vector_sub_recover_if.sv
// rtl/vector_sub_recover_if.sv - operand/result handshake bundle for vector_sub_recover
//
// Purpose : groups the input (y/b) and output (a/borrow) valid/ready channels.
// Modports: slave  - the recovery block (consumes y/b, produces a/borrow)
//           master - the environment driving y/b and accepting a/borrow
interface vector_sub_recover_if
  import vec_pkg::*;
#(
  parameter int W = LANE_W,
  parameter int N = NUM_LANES
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] y [N-1:0];
  logic [W-1:0] b [N-1:0];
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] a [N-1:0];
  logic [N-1:0] borrow;

  modport slave (
    input  in_valid, y, b, out_ready,
    output in_ready, out_valid, a, borrow
  );

  modport master (
    output in_valid, y, b, out_ready,
    input  in_ready, out_valid, a, borrow
  );

endinterface

// File: rtl/vec_lane_sub.sv
// rtl/vec_lane_sub.sv - single-lane unsigned subtract with borrow out
//
// Purpose: diff = (y - b) mod 2^W, borrow = (y < b) unsigned.
// Ports  : y, b (lane operands) -> diff, borrow.
module vec_lane_sub #(
  parameter int W = 8
) (
  input  logic [W-1:0] y,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W:0] wide;

  // One extra bit on top catches the borrow out of the lane.
  assign wide   = {1'b0, y} - {1'b0, b};
  assign diff   = wide[W-1:0];
  assign borrow = wide[W];

endmodule

// File: rtl/vector_sub_recover.sv
// rtl/vector_sub_recover.sv - two-stage pipelined per-lane y-b recovery with underflow stats
//
// Purpose : recovers a[i] = y[i] - b[i] mod 2^W for N independent lanes, flags
//           underflowing lanes, counts delivered transactions with any borrow.
// Ports   : clock, reset (sync, active-high)
//           bus      - vector_sub_recover_if.slave (in_valid/in_ready/y/b,
//                      out_valid/out_ready/a/borrow)
//           uf_count - saturating count of delivered transactions with |borrow
module vector_sub_recover
  import vec_pkg::*;
#(
  parameter int W     = LANE_W,
  parameter int N     = NUM_LANES,
  parameter int CNT_W = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  vector_sub_recover_if.slave   bus,
  output logic [CNT_W-1:0]      uf_count
);

  // Stage 1: operand register
  logic         s1_valid;
  logic [W-1:0] s1_y [N-1:0];
  logic [W-1:0] s1_b [N-1:0];

  // Stage 2: result register
  logic         s2_valid;
  logic [W-1:0] s2_a [N-1:0];
  logic [N-1:0] s2_borrow;

  logic [W-1:0] lane_diff [N-1:0];
  logic [N-1:0] lane_borrow;

  logic s1_load;
  logic s2_load;
  logic out_fire;

  // Stage 2 may take new data when empty or when its current result leaves
  // this cycle; stage 1 may take new data when empty or when it drains into
  // stage 2. This chains the ready so a full pipeline still streams 1/cycle.
  assign s2_load      = s1_valid && (!s2_valid || bus.out_ready);
  assign bus.in_ready = !reset && (!s1_valid || s2_load);
  assign s1_load      = bus.in_valid && bus.in_ready;
  assign out_fire     = s2_valid && bus.out_ready;

  for (genvar i = 0; i < N; i++) begin : g_lane
    vec_lane_sub #(.W(W)) u_lane (
      .y      (s1_y[i]),
      .b      (s1_b[i]),
      .diff   (lane_diff[i]),
      .borrow (lane_borrow[i])
    );
  end

  assign bus.out_valid = s2_valid;
  assign bus.a         = s2_a;
  assign bus.borrow    = s2_borrow;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s2_borrow <= '0;
      uf_count  <= '0;
      for (int i = 0; i < N; i++) begin
        s1_y[i] <= '0;
        s1_b[i] <= '0;
        s2_a[i] <= '0;
      end
    end else begin
      // Stage 1 bookkeeping: a refill in the same cycle as a drain keeps it full.
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_y     <= bus.y;
        s1_b     <= bus.b;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end

      // Stage 2 bookkeeping: results hold while the consumer stalls.
      if (s2_load) begin
        s2_valid  <= 1'b1;
        s2_a      <= lane_diff;
        s2_borrow <= lane_borrow;
      end else if (bus.out_ready) begin
        s2_valid <= 1'b0;
      end

      // Only transactions actually handed downstream are counted.
      if (out_fire && (|s2_borrow)) begin
        uf_count <= CNT_W'(sat_inc(32'(uf_count), 32'({CNT_W{1'b1}})));
      end
    end
  end

endmodule

// File: tb/tb_vector_sub_recover.sv
// tb/tb_vector_sub_recover.sv - self-checking bench for vector_sub_recover
module tb_vector_sub_recover;

  typedef struct packed {
    logic [3:0][7:0] y;
    logic [3:0][7:0] b;
    logic [3:0][7:0] a;
    logic [3:0]      eb;
  } vec_t;

  typedef struct packed {
    logic [3:0][7:0] a;
    logic [3:0]      borrow;
  } res_t;

  logic        clock;
  logic        reset;
  logic [15:0] uf_count;
  logic [1:0]  uf_sat;

  vector_sub_recover_if #(.W(8), .N(4)) mif ();
  vector_sub_recover_if #(.W(8), .N(4)) sif ();

  vector_sub_recover #(.W(8), .N(4), .CNT_W(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (mif.slave),
    .uf_count (uf_count)
  );

  vector_sub_recover #(.W(8), .N(4), .CNT_W(2)) dut_sat (
    .clock    (clock),
    .reset    (reset),
    .bus      (sif.slave),
    .uf_count (uf_sat)
  );

  assign sif.in_valid  = mif.in_valid;
  assign sif.y         = mif.y;
  assign sif.b         = mif.b;
  assign sif.out_ready = mif.out_ready;

  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 0;
  res_t sb_q[$];
  res_t cur_exp;
  logic [15:0] exp_uf = '0;
  int   run = 0;
  int   max_run = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic logic [3:0][7:0] lanes(input logic [7:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [3:0][7:0] get_a();
    logic [3:0][7:0] r;
    for (int i = 0; i < 4; i++) r[i] = mif.a[i];
    return r;
  endfunction

  function automatic res_t model(input logic [3:0][7:0] yv, input logic [3:0][7:0] bv);
    res_t r;
    for (int i = 0; i < 4; i++) begin
      r.a[i]      = yv[i] - bv[i];
      r.borrow[i] = (yv[i] < bv[i]);
    end
    return r;
  endfunction

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clock) begin
    if (mon_en) begin
      chk("uf_count", 64'(uf_count), 64'(exp_uf));
      if (reset) begin
        sb_q.delete();
        exp_uf = '0;
        run = 0;
      end else begin
        if (mif.in_valid && mif.in_ready) sb_q.push_back(cur_exp);
        if (mif.out_valid && mif.out_ready) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_output", 64'(get_a()), 64'hDEAD);
          end else begin
            res_t r;
            r = sb_q.pop_front();
            chk("out_a", 64'(get_a()), 64'(r.a));
            chk("out_borrow", 64'(mif.borrow), 64'(r.borrow));
            if (|r.borrow && exp_uf != 16'hFFFF) exp_uf = exp_uf + 16'd1;
          end
          run++;
          if (run > max_run) max_run = run;
        end else begin
          run = 0;
        end
      end
    end
  end

  task automatic sample();
    @(negedge clock);
    #1;
  endtask

  task automatic to_drive();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input logic [3:0][7:0] yv, input logic [3:0][7:0] bv, input res_t e);
    cur_exp = e;
    for (int i = 0; i < 4; i++) begin
      mif.y[i] = yv[i];
      mif.b[i] = bv[i];
    end
    mif.in_valid = 1'b1;
  endtask

  // Presents a transaction and returns at the drive phase after it is accepted.
  task automatic send(input logic [3:0][7:0] yv, input logic [3:0][7:0] bv,
                      input res_t e, output int waited);
    set_in(yv, bv, e);
    waited = 0;
    forever begin
      sample();
      if (mif.in_ready) break;
      waited++;
      if (waited > 50) begin
        chk("send_timeout", 64'(waited), 64'd0);
        break;
      end
    end
    to_drive();
  endtask

  task automatic wait_drain();
    int n = 0;
    do begin
      sample();
      n++;
    end while ((sb_q.size() != 0 || mif.out_valid) && n < 100);
    if (n >= 100) chk("drain_timeout", 64'(sb_q.size()), 64'd0);
    to_drive();
  endtask

  task automatic pulse_reset();
    mif.in_valid = 1'b0;
    reset = 1'b1;
    to_drive();
    reset = 1'b0;
  endtask

  vec_t tbl [4];
  int   sat_seq [5];

  initial begin
    int   w;
    res_t e;
    vec_t t [3];
    logic [3:0][7:0] ry, rb;

    tbl[0] = '{y: lanes(10, 20, 30, 40),    b: lanes(3, 5, 7, 9),
               a: lanes(7, 15, 23, 31),     eb: 4'b0000};
    tbl[1] = '{y: lanes(0, 5, 255, 128),    b: lanes(1, 5, 0, 200),
               a: lanes(255, 0, 255, 184),  eb: 4'b1001};
    tbl[2] = '{y: lanes(255, 255, 255, 255), b: lanes(255, 0, 254, 1),
               a: lanes(0, 255, 1, 254),    eb: 4'b0000};
    tbl[3] = '{y: lanes(0, 0, 0, 0),        b: lanes(255, 1, 128, 0),
               a: lanes(1, 255, 128, 0),    eb: 4'b0111};
    sat_seq = '{1, 2, 3, 3, 3};

    reset = 1'b1;
    mif.in_valid = 1'b0;
    mif.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mif.y[i] = '0;
      mif.b[i] = '0;
    end
    repeat (3) sample();
    chk("rst_in_ready", 64'(mif.in_ready), 64'd0);
    chk("rst_out_valid", 64'(mif.out_valid), 64'd0);
    chk("rst_a", 64'(get_a()), 64'd0);
    chk("rst_borrow", 64'(mif.borrow), 64'd0);
    chk("rst_uf", 64'(uf_count), 64'd0);
    to_drive();
    reset = 1'b0;
    mon_en = 1'b1;

    // Single transactions from the table, with latency check.
    for (int r = 0; r < 4; r++) begin
      e.a = tbl[r].a;
      e.borrow = tbl[r].eb;
      send(tbl[r].y, tbl[r].b, e, w);
      mif.in_valid = 1'b0;
      sample();
      chk("latency_cycle1", 64'(mif.out_valid), 64'd0);
      sample();
      chk("latency_cycle2", 64'(mif.out_valid), 64'd1);
      to_drive();
      wait_drain();
    end

    // Back-to-back stream of 8.
    max_run = 0;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 4; i++) begin
        ry[i] = 8'($urandom_range(0, 255));
        rb[i] = 8'($urandom_range(0, 255));
      end
      send(ry, rb, model(ry, rb), w);
      chk("stream_in_ready", 64'(w), 64'd0);
    end
    mif.in_valid = 1'b0;
    wait_drain();
    chk("stream_run", 64'(max_run), 64'd8);

    // Backpressure: stall with three in flight.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        t[k].y[i] = 8'($urandom_range(0, 255));
        t[k].b[i] = 8'($urandom_range(0, 255));
      end
    end
    mif.out_ready = 1'b0;
    send(t[0].y, t[0].b, model(t[0].y, t[0].b), w);
    send(t[1].y, t[1].b, model(t[1].y, t[1].b), w);
    chk("bp_second_accept", 64'(w), 64'd0);
    e = model(t[0].y, t[0].b);
    set_in(t[2].y, t[2].b, model(t[2].y, t[2].b));
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("bp_in_ready_low", 64'(mif.in_ready), 64'd0);
      chk("bp_out_valid", 64'(mif.out_valid), 64'd1);
      chk("bp_a_hold", 64'(get_a()), 64'(e.a));
    end
    to_drive();
    mif.out_ready = 1'b1;
    w = 0;
    forever begin
      sample();
      if (mif.in_ready || w > 50) break;
      w++;
    end
    chk("bp_third_accept", 64'(mif.in_ready), 64'd1);
    to_drive();
    mif.in_valid = 1'b0;
    wait_drain();

    // Reset with two transactions in flight.
    mif.out_ready = 1'b0;
    e = model(tbl[0].y, tbl[0].b);
    send(tbl[0].y, tbl[0].b, e, w);
    e = model(tbl[1].y, tbl[1].b);
    send(tbl[1].y, tbl[1].b, e, w);
    mif.in_valid = 1'b0;
    reset = 1'b1;
    sample();
    chk("mid_rst_in_ready", 64'(mif.in_ready), 64'd0);
    to_drive();
    reset = 1'b0;
    mif.out_ready = 1'b1;
    sample();
    chk("post_rst_in_ready", 64'(mif.in_ready), 64'd1);
    chk("post_rst_a", 64'(get_a()), 64'd0);
    chk("post_rst_uf", 64'(uf_count), 64'd0);
    for (int k = 0; k < 4; k++) begin
      sample();
      chk("post_rst_no_out", 64'(mif.out_valid), 64'd0);
    end
    to_drive();

    // Saturation on the 2-bit counter instance.
    pulse_reset();
    e.a = tbl[1].a;
    e.borrow = tbl[1].eb;
    for (int k = 0; k < 5; k++) begin
      send(tbl[1].y, tbl[1].b, e, w);
      mif.in_valid = 1'b0;
      wait_drain();
      chk("sat_uf", 64'(uf_sat), 64'(sat_seq[k]));
    end

    sample();
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
